fwd_ctrl: RTL
=============

FWD_CTRL -- requirements
Module: fwd_ctrl

Interface
REQ-001 Parameter REG_AW, default 5, register-address width.
REQ-002 Parameter CNT_W, default 16, stall-counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 id_valid  input  1  decode stage holds a valid instruction.
REQ-006 id_rs1  input  REG_AW  decode source register A.
REQ-007 id_rs2  input  REG_AW  decode source register B.
REQ-008 id_rd  input  REG_AW  decode destination register.
REQ-009 id_regwrite  input  1  decode instruction writes id_rd.
REQ-010 id_memread  input  1  decode instruction is a load.
REQ-011 flush  input  1  kill decode and EX instructions (taken branch).
REQ-012 stall  output  1  hold PC and IF/ID; combinational.
REQ-013 fwd_a  output  2  operand-A mux select for the instruction in EX; registered.
REQ-014 fwd_b  output  2  operand-B mux select for the instruction in EX; registered.
REQ-015 stall_cnt  output  CNT_W  saturating count of stall cycles.

Function
REQ-016 Select encoding SHALL be: 00 register file, 01 MEM-stage result, 10 WB-stage result, 11 retired (post-WB) result.
REQ-017 Block SHALL track valid, rd, regwrite, load for stages EX, MEM, WB, RET; each edge without stall shifts ID->EX->MEM->WB->RET.
REQ-018 Select for source rsX SHALL be computed at decode against EX/MEM/WB tracker entries and registered into fwd_a/fwd_b with the instruction: EX match->01, MEM match->10, WB match->11, else 00.
REQ-019 Match SHALL require entry valid, regwrite=1, rd==rsX, rsX!=0; youngest match wins.
REQ-020 stall SHALL assert when id_valid, EX entry valid, load=1, regwrite=1, rd!=0, and rd equals id_rs1 or id_rs2.
REQ-021 On a stall cycle, EX entry SHALL load a bubble (valid=0), fwd_a/fwd_b SHALL load 00, MEM/WB/RET SHALL still advance.
REQ-022 After one stall cycle the load is in MEM; re-evaluation SHALL produce select 10 with no further stall.
REQ-023 flush SHALL load a bubble into EX and SHALL force stall low that cycle; flush has priority over stall.
REQ-024 id_valid=0 SHALL load a bubble into EX with selects 00.
REQ-025 stall_cnt SHALL increment by 1 per stall cycle and hold at 2^CNT_W-1.
REQ-026 Simultaneous rs1==rs2 matches SHALL give identical fwd_a and fwd_b.

Reset
REQ-027 rst SHALL asynchronously clear all tracker valid bits, rd/regwrite/load fields, fwd_a, fwd_b, stall_cnt to 0.
REQ-028 stall SHALL read 0 while rst is high and on the first cycle after release.
REQ-029 rst mid-stall SHALL discard the stalled hazard; no residual stall after release.

Configuration
REQ-030 Macro FWD_RET_BYPASS_EN: defined -> RET path and select 11 as in REQ-016/REQ-018.
REQ-031 FWD_RET_BYPASS_EN undefined -> RET tracking not built; WB-entry matches give 00 (register file write-first); select 11 never produced.

Verification
REQ-032 add x5 then add x6,x5,x1 back-to-back -> consumer in EX sees fwd_a=01, fwd_b=00, stall=0.
REQ-033 lw x7 then add x8,x2,x7 -> stall=1 one cycle, stall_cnt 0->1, consumer in EX with fwd_b=10.
REQ-034 writer x3, two independent instrs, reader x3 -> fwd_a=11 with macro, 00 without.
REQ-035 writer x0 then reader x0 -> fwd_a=00; lw x0 then reader x0 -> stall=0.
REQ-036 lw x9 then reader x9 with flush=1 same cycle -> stall=0, EX bubble, selects 00.
REQ-037 rst asserted mid-stall, 2 cycles, released -> all outputs 0, stall_cnt=0, next reader gets 00.

Source files
------------

// File: rtl/fwd_ctrl.sv
// fwd_ctrl -- operand-forwarding and load-use interlock controller.
//
// Tracks the instructions in EX, MEM and WB (and RET when FWD_RET_BYPASS_EN
// is defined). It compares the decode-stage sources against those entries
// and registers the operand-mux selects into fwd_a/fwd_b as the instruction
// moves into EX.
//
// Select encoding: 00 register file, 01 MEM result, 10 WB result,
// 11 retired (post-WB) result.
//
// Build option:
//   FWD_RET_BYPASS_EN  defined   -> RET tracker stage built; a WB-entry match
//                                   selects 11.
//                      undefined -> no RET stage; a WB-entry match selects 00
//                                   (the register file is write-first).
//
// Ports:
//   clk, rst       clock; asynchronous active-high reset
//   id_valid       decode stage holds a valid instruction
//   id_rs1/id_rs2  decode source registers
//   id_rd          decode destination register
//   id_regwrite    decode instruction writes id_rd
//   id_memread     decode instruction is a load
//   flush          kill the decode instruction (taken branch)
//   stall          hold PC and IF/ID (combinational)
//   fwd_a/fwd_b    registered operand mux selects for the EX instruction
//   stall_cnt      saturating count of stall cycles
module fwd_ctrl #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              flush,
  output logic              stall,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt
);

`ifdef FWD_RET_BYPASS_EN
  localparam int unsigned NSTG = 4;
`else
  localparam int unsigned NSTG = 3;
`endif

  typedef enum logic [1:0] {
    SEL_RF  = 2'b00,
    SEL_MEM = 2'b01,
    SEL_WB  = 2'b10,
    SEL_RET = 2'b11
  } sel_e;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              load;
  } ent_t;

  // Index 0 = EX, 1 = MEM, 2 = WB, 3 = RET (3 only with the bypass option).
  ent_t trk [NSTG];
  ent_t id_ent;
  sel_e sel_a, sel_b;
  logic advance;

  function automatic logic hit(input ent_t e, input logic [REG_AW-1:0] rs);
    return e.valid && e.regwrite && (e.rd == rs) && (rs != '0);
  endfunction

  assign id_ent = {1'b1, id_rd, id_regwrite, id_memread};

  // A load in EX cannot supply its result to the next instruction yet.
  // flush overrides the interlock because the decode instruction is killed.
  assign stall = id_valid && !flush && trk[0].valid && trk[0].load &&
                 trk[0].regwrite && (trk[0].rd != '0) &&
                 ((trk[0].rd == id_rs1) || (trk[0].rd == id_rs2));

  assign advance = id_valid && !flush && !stall;

  // Oldest stage is checked first so that younger matches overwrite it.
  // The entry now in EX will be in MEM when the consumer reaches EX, so
  // the select is one stage further down the pipe than the entry matched.
  always_comb begin
    sel_a = SEL_RF;
    sel_b = SEL_RF;
`ifdef FWD_RET_BYPASS_EN
    if (hit(trk[2], id_rs1)) sel_a = SEL_RET;
    if (hit(trk[2], id_rs2)) sel_b = SEL_RET;
`endif
    if (hit(trk[1], id_rs1)) sel_a = SEL_WB;
    if (hit(trk[1], id_rs2)) sel_b = SEL_WB;
    if (hit(trk[0], id_rs1)) sel_a = SEL_MEM;
    if (hit(trk[0], id_rs2)) sel_b = SEL_MEM;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NSTG; i++) trk[i] <= '0;
      fwd_a     <= '0;
      fwd_b     <= '0;
      stall_cnt <= '0;
    end else begin
      // Older stages always advance, even while decode is held.
      for (int unsigned i = 1; i < NSTG; i++) trk[i] <= trk[i-1];
      if (advance) begin
        trk[0] <= id_ent;
        fwd_a  <= sel_a;
        fwd_b  <= sel_b;
      end else begin
        trk[0] <= '0;
        fwd_a  <= SEL_RF;
        fwd_b  <= SEL_RF;
      end
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
